// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream stage.
package async_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int BUF_DEPTH = 3;

  typedef logic [1:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD,
    FLUSH
  } rd_state_e;

  // Advance a buffer pointer modulo BUF_DEPTH (0,1,2,0,...).
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? ptr_t'(0) : p + 2'd1;
  endfunction

endpackage

// File: rtl/async_fifo_rd_skid_buf.sv
// Three-entry register buffer with head/tail pointers and occupancy.
// clear_i empties the buffer (pointers and count) and overrides push/pop.
module async_fifo_rd_skid_buf
  import async_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       occ_o,
  output logic [WIDTH-1:0] head_data_o
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  ptr_t             head_q;
  ptr_t             tail_q;
  logic [1:0]       occ_q;

  // Storage, pointers and occupancy update on push/pop/clear.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      // NOTE: storage is reset here only because the stream data output must
      // read zero out of reset; a wider buffer would normally skip this.
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= ptr_inc(tail_q);
      end
      if (pop_i) head_q <= ptr_inc(head_q);
      occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  assign occ_o       = occ_q;
  assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Read-side consumer of the async FIFO: issues read enables from the empty
// flag using registered credits only, absorbs the 1-cycle read latency and
// presents a valid/ready stream from a 3-entry buffer. Sticky error flag and
// synchronous flush. Optional statistics counters: ASYNC_FIFO_RD_STATS_EN.
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int BUF_DEPTH = async_fifo_pkg::BUF_DEPTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_rdata_i,
  input  logic             fifo_rd_error_i,
  output logic             fifo_rd_en_o,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o,
  output logic             err_o
`ifdef ASYNC_FIFO_RD_STATS_EN
  ,
  output logic [31:0]      rd_cnt_o,
  output logic [15:0]      flush_drop_cnt_o
`endif
);

  localparam logic [2:0] CREDITS = 3'(BUF_DEPTH);

  rd_state_e  state_q;
  rd_state_e  state_nxt;
  logic       inflight_q;
  logic       drop_pending_q;
  logic       err_q;
  logic [1:0] occ;
  logic       push;
  logic       pop;
  logic [2:0] credits_used;
  logic [2:0] occ_nxt;
  logic [2:0] credits_nxt;

  // Credits come from registered occupancy and in-flight state only, so
  // m_ready_i never reaches the FIFO read enable combinationally.
  assign credits_used = {1'b0, occ} + {2'b0, inflight_q};
  assign fifo_rd_en_o = !rst_i && !fifo_empty_i && !flush_i &&
                        (credits_used < CREDITS) && (state_q != FLUSH);

  // A returning word is captured unless a flush is discarding it.
  assign push      = inflight_q && (state_q != FLUSH);
  // A flush in the same cycle as a handshake swallows the pop.
  assign pop       = m_valid_o && m_ready_i && !flush_i;
  assign m_valid_o = (occ != 2'd0);
  assign err_o     = err_q;

  async_fifo_rd_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (flush_i),
    .push_i      (push),
    .push_data_i (fifo_rdata_i),
    .pop_i       (pop),
    .occ_o       (occ),
    .head_data_o (m_data_o)
  );

  // Next state for normal operation, derived from next-cycle credit usage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt   = RUN;
    occ_nxt     = {1'b0, occ} + {2'b0, push} - {2'b0, pop};
    credits_nxt = occ_nxt + {2'b0, fifo_rd_en_o};
    if (credits_nxt == CREDITS)    state_nxt = HOLD;
    else if (credits_nxt == 3'd0)  state_nxt = IDLE;
  end

  // FSM, in-flight tracking and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      inflight_q     <= 1'b0;
      drop_pending_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      inflight_q <= fifo_rd_en_o;
      err_q      <= err_q | fifo_rd_error_i;
      if (flush_i) begin
        state_q        <= FLUSH;
        drop_pending_q <= inflight_q;
      end else if (state_q == FLUSH) begin
        // One extra cycle in FLUSH when a word was in flight at flush time.
        if (drop_pending_q) drop_pending_q <= 1'b0;
        else                state_q        <= IDLE;
      end else begin
        state_q <= state_nxt;
      end
    end
  end

`ifdef ASYNC_FIFO_RD_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, flush_drop_cnt_o} + {14'd0, credits_used};

  // Saturating counters of stream pops and words discarded by flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_cnt_o         <= '0;
      flush_drop_cnt_o <= '0;
    end else begin
      if (pop && (rd_cnt_o != '1)) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (flush_i) flush_drop_cnt_o <= drop_sum[16] ? '1 : drop_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed testbench for async_fifo_rd_stream. The FIFO is modelled inline:
// each accepted read returns the next word of a counting sequence one cycle
// later. Build with ASYNC_FIFO_RD_STATS_EN to also check the counters.
module tb_async_fifo_rd_stream;
  import async_fifo_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_rdata_i;
  logic       fifo_rd_error_i;
  logic       fifo_rd_en_o;
  logic       m_valid_o;
  logic       m_ready_i;
  logic [7:0] m_data_o;
  logic       err_o;
`ifdef ASYNC_FIFO_RD_STATS_EN
  logic [31:0] rd_cnt_o;
  logic [15:0] flush_drop_cnt_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int rd_pulses;
  logic [7:0] next_word;

  async_fifo_rd_stream #(.WIDTH(8)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_rdata_i    (fifo_rdata_i),
    .fifo_rd_error_i (fifo_rd_error_i),
    .fifo_rd_en_o    (fifo_rd_en_o),
    .m_valid_o       (m_valid_o),
    .m_ready_i       (m_ready_i),
    .m_data_o        (m_data_o),
    .err_o           (err_o)
`ifdef ASYNC_FIFO_RD_STATS_EN
    ,
    .rd_cnt_o         (rd_cnt_o),
    .flush_drop_cnt_o (flush_drop_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the FIFO model presents read data after an accepted read.
  task automatic step();
    logic was_rd;
    was_rd = fifo_rd_en_o;
    @(posedge clk_i);
    #1;
    if (was_rd === 1'b1) begin
      rd_pulses++;
      fifo_rdata_i = next_word;
      next_word    = next_word + 8'd1;
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; fifo_empty_i = 1'b1; fifo_rdata_i = '0;
    fifo_rd_error_i = 1'b0; m_ready_i = 1'b0; next_word = 8'h11; rd_pulses = 0;

    // Reset state
    step(); step(); #1;
    check("rst_rd_en", fifo_rd_en_o, 0);
    check("rst_valid", m_valid_o, 0);
    check("rst_data",  m_data_o, 0);
    check("rst_err",   err_o, 0);
    check("rst_state", 32'(dut.state_q), 32'(IDLE));
    rst_i = 1'b0;
    step();

    // Basic flow: four words, consumer always ready
    rd_pulses = 0; m_ready_i = 1'b1; fifo_empty_i = 1'b0; #1;
    check("a0_rd_en", fifo_rd_en_o, 1);
    check("a0_valid", m_valid_o, 0);
    step(); #1;
    check("a1_rd_en", fifo_rd_en_o, 1);
    check("a1_valid", m_valid_o, 0);
    check("a1_state", 32'(dut.state_q), 32'(RUN));
    step(); #1;
    check("a2_valid", m_valid_o, 1);
    check("a2_data",  m_data_o, 8'h11);
    check("a2_rd_en", fifo_rd_en_o, 1);
    step(); #1;
    check("a3_data",  m_data_o, 8'h12);
    step(); fifo_empty_i = 1'b1; #1;
    check("a4_rd_en", fifo_rd_en_o, 0);
    check("a4_data",  m_data_o, 8'h13);
    step(); #1;
    check("a5_valid", m_valid_o, 1);
    check("a5_data",  m_data_o, 8'h14);
    step(); #1;
    check("a6_valid", m_valid_o, 0);
    check("a6_state", 32'(dut.state_q), 32'(IDLE));
    check("a_pulses", rd_pulses, 4);

    // Backpressure: three reads then HOLD, head word stable
    m_ready_i = 1'b0; next_word = 8'h21; rd_pulses = 0; fifo_empty_i = 1'b0; #1;
    check("b0_rd_en", fifo_rd_en_o, 1);
    step(); #1;
    check("b1_rd_en", fifo_rd_en_o, 1);
    step(); #1;
    check("b2_rd_en", fifo_rd_en_o, 1);
    check("b2_data",  m_data_o, 8'h21);
    step(); #1;
    check("b3_rd_en", fifo_rd_en_o, 0);
    check("b3_state", 32'(dut.state_q), 32'(HOLD));
    step(); #1;
    check("b4_rd_en", fifo_rd_en_o, 0);
    check("b4_data",  m_data_o, 8'h21);
    step(); #1;
    check("b5_state", 32'(dut.state_q), 32'(HOLD));
    check("b5_data",  m_data_o, 8'h21);
    check("b_pulses", rd_pulses, 3);
    m_ready_i = 1'b1; #1;
    check("c0_rd_en", fifo_rd_en_o, 0);
    check("c0_data",  m_data_o, 8'h21);
    step(); #1;
    check("c1_state", 32'(dut.state_q), 32'(RUN));
    check("c1_rd_en", fifo_rd_en_o, 1);
    check("c1_data",  m_data_o, 8'h22);
    step(); fifo_empty_i = 1'b1; #1;
    check("c2_rd_en", fifo_rd_en_o, 0);
    check("c2_data",  m_data_o, 8'h23);
    step(); #1;
    check("c3_data",  m_data_o, 8'h24);
    step(); #1;
    check("c4_valid", m_valid_o, 0);
    check("c_pulses", rd_pulses, 4);

    // Empty rises the cycle after a read: in-flight word still delivered
    next_word = 8'h31; rd_pulses = 0; fifo_empty_i = 1'b0; #1;
    check("d0_rd_en", fifo_rd_en_o, 1);
    step(); fifo_empty_i = 1'b1; #1;
    check("d1_rd_en", fifo_rd_en_o, 0);
    step(); #1;
    check("d2_valid", m_valid_o, 1);
    check("d2_data",  m_data_o, 8'h31);
    step(); #1;
    check("d3_valid", m_valid_o, 0);
    check("d_pulses", rd_pulses, 1);

    // Flush with occ=2 and one word in flight
    m_ready_i = 1'b0; next_word = 8'h41; fifo_empty_i = 1'b0; #1;
    step(); step(); step(); #1;
    check("e3_state", 32'(dut.state_q), 32'(HOLD));
    flush_i = 1'b1; #1;
    check("e3_rd_en", fifo_rd_en_o, 0);
    step(); flush_i = 1'b0; #1;
    check("e4_valid", m_valid_o, 0);
    check("e4_state", 32'(dut.state_q), 32'(FLUSH));
    check("e4_rd_en", fifo_rd_en_o, 0);
    step(); #1;
    check("e5_state", 32'(dut.state_q), 32'(FLUSH));
    check("e5_valid", m_valid_o, 0);
    fifo_empty_i = 1'b1;
    step(); #1;
    check("e6_state", 32'(dut.state_q), 32'(IDLE));
    check("e6_valid", m_valid_o, 0);
`ifdef ASYNC_FIFO_RD_STATS_EN
    check("e6_drop_cnt", flush_drop_cnt_o, 3);
`endif
    // Next word after the flush is fresh; the dropped 0x43 never appears
    fifo_empty_i = 1'b0; m_ready_i = 1'b1; #1;
    check("e7_rd_en", fifo_rd_en_o, 1);
    step(); fifo_empty_i = 1'b1; #1;
    check("e8_valid", m_valid_o, 0);
    step(); #1;
    check("e9_data",  m_data_o, 8'h44);
    // Flush together with a pop: flush wins
    flush_i = 1'b1; #1;
    step(); flush_i = 1'b0; #1;
    check("e10_valid", m_valid_o, 0);
    check("e10_state", 32'(dut.state_q), 32'(FLUSH));
    step(); #1;
    check("e11_state", 32'(dut.state_q), 32'(IDLE));
`ifdef ASYNC_FIFO_RD_STATS_EN
    check("e11_rd_cnt",   rd_cnt_o, 9);
    check("e11_drop_cnt", flush_drop_cnt_o, 4);
`endif

    // Sticky error, then reset mid-stream with occ=2 and one word in flight
    fifo_rd_error_i = 1'b1; m_ready_i = 1'b0; #1;
    check("f0_err", err_o, 0);
    step(); fifo_rd_error_i = 1'b0; fifo_empty_i = 1'b0; #1;
    check("f1_err",   err_o, 1);
    check("f1_rd_en", fifo_rd_en_o, 1);
    step(); #1;
    check("f2_err",   err_o, 1);
    step(); #1;
    check("f3_err",   err_o, 1);
    check("f3_data",  m_data_o, 8'h45);
    step(); #1;
    check("f4_err",   err_o, 1);
    check("f4_rd_en", fifo_rd_en_o, 0);
    check("f4_valid", m_valid_o, 1);
    rst_i = 1'b1; fifo_empty_i = 1'b1;
    step(); #1;
    check("f5_rd_en", fifo_rd_en_o, 0);
    check("f5_valid", m_valid_o, 0);
    check("f5_data",  m_data_o, 0);
    check("f5_err",   err_o, 0);
    check("f5_state", 32'(dut.state_q), 32'(IDLE));
`ifdef ASYNC_FIFO_RD_STATS_EN
    check("f5_rd_cnt",   rd_cnt_o, 0);
    check("f5_drop_cnt", flush_drop_cnt_o, 0);
`endif
    rst_i = 1'b0;
    step(); #1;
    check("f6_valid", m_valid_o, 0);
    check("f6_data",  m_data_o, 0);
    step(); #1;
    check("f7_valid", m_valid_o, 0);
    check("f7_err",   err_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
